// File: rtl/swc_pump_pkg.sv
// Shared constants and types for the packet-memory read/write pumps.
package swc_pump_pkg;

  localparam int PAGE_ADDR_BITS = 10;
  localparam int PAGE_SIZE      = 128;
  localparam int DATA_WIDTH     = 20;
  localparam int MULTIPLY       = 16;
  localparam int WIDE_PER_PAGE  = PAGE_SIZE / MULTIPLY;
  localparam int WIDE_WIDTH     = DATA_WIDTH * MULTIPLY;
  localparam int NIDX_BITS      = $clog2(MULTIPLY);
  localparam int WIDX_BITS      = $clog2(WIDE_PER_PAGE);
  // One extra bit so the wide index can sit at "page fully issued".
  localparam int WCNT_BITS      = WIDX_BITS + 1;

  typedef enum logic [1:0] {
    LL_IDLE = 2'd0,
    LL_REQ  = 2'd1,
    LL_HAVE = 2'd2
  } ll_state_e;

  typedef logic [MULTIPLY-1:0][DATA_WIDTH-1:0] wide_word_t;

endpackage

// File: rtl/swc_pump_unpacker.sv
// Double-buffered wide-to-narrow unpacker: active word A, holding word H.
module swc_pump_unpacker
  import swc_pump_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  ld_i,
  input  logic                  ld_last_i,
  input  logic [WIDE_WIDTH-1:0] d_i,
  input  logic                  pop_i,
  output logic                  drdy_o,
  output logic [DATA_WIDTH-1:0] q_o,
  output logic                  pgend_o,
  output logic                  h_full_o
);

  wide_word_t           a_q, a_d, h_q, h_d;
  logic                 va_q, va_d, vh_q, vh_d;
  logic                 la_q, la_d, lh_q, lh_d;
  logic [NIDX_BITS-1:0] nidx_q, nidx_d;
  logic                 pop, last_pop;

  // Pop qualification: a pop of narrow word 15 frees the whole A slot.
  always_comb begin
    pop      = va_q & pop_i;
    last_pop = pop & (nidx_q == NIDX_BITS'(MULTIPLY - 1));
  end

  // Buffer update: shift H into A on a full pop, then place returning data in the first free slot.
  always_comb begin
    a_d    = a_q;
    h_d    = h_q;
    va_d   = va_q;
    vh_d   = vh_q;
    la_d   = la_q;
    lh_d   = lh_q;
    nidx_d = nidx_q;
    if (clr_i) begin
      va_d   = 1'b0;
      vh_d   = 1'b0;
      nidx_d = '0;
    end else begin
      if (pop) begin
        nidx_d = last_pop ? '0 : nidx_q + NIDX_BITS'(1);
      end
      if (last_pop) begin
        a_d  = h_q;
        va_d = vh_q;
        la_d = lh_q;
        vh_d = 1'b0;
      end
      if (ld_i) begin
        if (!va_d) begin
          a_d  = d_i;
          va_d = 1'b1;
          la_d = ld_last_i;
        end else begin
          h_d  = d_i;
          vh_d = 1'b1;
          lh_d = ld_last_i;
        end
      end
    end
  end

  // Buffer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q    <= '0;
      h_q    <= '0;
      va_q   <= 1'b0;
      vh_q   <= 1'b0;
      la_q   <= 1'b0;
      lh_q   <= 1'b0;
      nidx_q <= '0;
    end else begin
      a_q    <= a_d;
      h_q    <= h_d;
      va_q   <= va_d;
      vh_q   <= vh_d;
      la_q   <= la_d;
      lh_q   <= lh_d;
      nidx_q <= nidx_d;
    end
  end

  // Output side: narrow word select, first word in the LSBs.
  always_comb begin
    drdy_o   = va_q;
    q_o      = a_q[nidx_q];
    pgend_o  = last_pop & la_q;
    h_full_o = vh_q;
  end

endmodule

// File: rtl/swc_packet_mem_read_pump.sv
// Packet-memory read pump: slot-timed wide reads, linked-list page following, narrow output.
module swc_packet_mem_read_pump
  import swc_pump_pkg::*;
(
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [PAGE_ADDR_BITS-1:0]           pgaddr_i,
  input  logic                                pgreq_i,
  input  logic                                flush_i,
  output logic                                pgend_o,
  input  logic                                sync_i,
  output logic                                rd_o,
  output logic [PAGE_ADDR_BITS+WIDX_BITS-1:0] addr_o,
  input  logic [WIDE_WIDTH-1:0]               d_i,
  output logic [PAGE_ADDR_BITS-1:0]           ll_addr_o,
  output logic                                ll_rd_req_o,
  input  logic [PAGE_ADDR_BITS-1:0]           ll_data_i,
  input  logic                                ll_rd_done_i,
  output logic                                drdy_o,
  input  logic                                dreq_i,
  output logic [DATA_WIDTH-1:0]               q_o
);

  ll_state_e                 ll_state_q, ll_state_d;
  logic                      active_q, active_d;
  logic [PAGE_ADDR_BITS-1:0] cur_page_q, cur_page_d;
  logic [PAGE_ADDR_BITS-1:0] next_page_q, next_page_d;
  logic [WCNT_BITS-1:0]      wide_idx_q, wide_idx_d;
  logic                      inf_q, inf_d;
  logic                      inf_last_q, inf_last_d;
  logic                      h_full, page_ok, page_switch;

  // Read issue and page-switch decisions from current state.
  always_comb begin
    page_ok     = wide_idx_q < WCNT_BITS'(WIDE_PER_PAGE);
    page_switch = active_q & (wide_idx_q == WCNT_BITS'(WIDE_PER_PAGE)) & (ll_state_q == LL_HAVE);
    rd_o        = active_q & sync_i & ~h_full & ~inf_q & page_ok;
    addr_o      = {cur_page_q, wide_idx_q[WIDX_BITS-1:0]};
  end

  // Page, wide index and in-flight bookkeeping; start beats flush beats normal flow.
  always_comb begin
    active_d    = active_q;
    cur_page_d  = cur_page_q;
    next_page_d = next_page_q;
    wide_idx_d  = wide_idx_q;
    inf_d       = 1'b0;
    inf_last_d  = inf_last_q;
    if (pgreq_i) begin
      active_d   = 1'b1;
      cur_page_d = pgaddr_i;
      wide_idx_d = '0;
    end else if (flush_i) begin
      active_d = 1'b0;
    end else begin
      if (rd_o) begin
        inf_d      = 1'b1;
        inf_last_d = (wide_idx_q == WCNT_BITS'(WIDE_PER_PAGE - 1));
        wide_idx_d = wide_idx_q + WCNT_BITS'(1);
      end
      if (page_switch) begin
        cur_page_d = next_page_q;
        wide_idx_d = '0;
      end
      if ((ll_state_q == LL_REQ) && ll_rd_done_i) begin
        next_page_d = ll_data_i;
      end
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q    <= 1'b0;
      cur_page_q  <= '0;
      next_page_q <= '0;
      wide_idx_q  <= '0;
      inf_q       <= 1'b0;
      inf_last_q  <= 1'b0;
    end else begin
      active_q    <= active_d;
      cur_page_q  <= cur_page_d;
      next_page_q <= next_page_d;
      wide_idx_q  <= wide_idx_d;
      inf_q       <= inf_d;
      inf_last_q  <= inf_last_d;
    end
  end

  // Linked-list FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ll_state_q <= LL_IDLE;
    end else begin
      ll_state_q <= ll_state_d;
    end
  end

  // Linked-list FSM next state: restart on start or page switch, park on flush.
  always_comb begin
    ll_state_d = ll_state_q;
    if (pgreq_i) begin
      ll_state_d = LL_REQ;
    end else if (flush_i) begin
      ll_state_d = LL_IDLE;
    end else begin
      case (ll_state_q)
        LL_REQ:  if (ll_rd_done_i) ll_state_d = LL_HAVE;
        LL_HAVE: if (page_switch) ll_state_d = LL_REQ;
        default: ll_state_d = ll_state_q;
      endcase
    end
  end

  // Linked-list FSM outputs: request the successor of the current page.
  always_comb begin
    ll_rd_req_o = (ll_state_q == LL_REQ);
    ll_addr_o   = ll_rd_req_o ? cur_page_q : '0;
  end

  swc_pump_unpacker u_unpacker (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (pgreq_i | flush_i),
    .ld_i      (inf_q),
    .ld_last_i (inf_last_q),
    .d_i       (d_i),
    .pop_i     (dreq_i),
    .drdy_o    (drdy_o),
    .q_o       (q_o),
    .pgend_o   (pgend_o),
    .h_full_o  (h_full)
  );

endmodule

// File: tb/tb_swc_packet_mem_read_pump.sv
// Scoreboard bench for the packet-memory read pump.
module tb_swc_packet_mem_read_pump;
  import swc_pump_pkg::*;

  logic                                clk_i = 1'b0;
  logic                                rst_i = 1'b1;
  logic [PAGE_ADDR_BITS-1:0]           pgaddr_i = '0;
  logic                                pgreq_i = 1'b0;
  logic                                flush_i = 1'b0;
  logic                                pgend_o;
  logic                                sync_i = 1'b0;
  logic                                rd_o;
  logic [PAGE_ADDR_BITS+WIDX_BITS-1:0] addr_o;
  logic [WIDE_WIDTH-1:0]               d_i = '0;
  logic [PAGE_ADDR_BITS-1:0]           ll_addr_o;
  logic                                ll_rd_req_o;
  logic [PAGE_ADDR_BITS-1:0]           ll_data_i = '0;
  logic                                ll_rd_done_i = 1'b0;
  logic                                drdy_o;
  logic                                dreq_i = 1'b0;
  logic [DATA_WIDTH-1:0]               q_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ll_delay = 4;
  int ll_cnt = 0;

  logic [DATA_WIDTH:0] exp_q[$];
  logic [12:0]         addr_q[$];

  swc_packet_mem_read_pump dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pgaddr_i     (pgaddr_i),
    .pgreq_i      (pgreq_i),
    .flush_i      (flush_i),
    .pgend_o      (pgend_o),
    .sync_i       (sync_i),
    .rd_o         (rd_o),
    .addr_o       (addr_o),
    .d_i          (d_i),
    .ll_addr_o    (ll_addr_o),
    .ll_rd_req_o  (ll_rd_req_o),
    .ll_data_i    (ll_data_i),
    .ll_rd_done_i (ll_rd_done_i),
    .drdy_o       (drdy_o),
    .dreq_i       (dreq_i),
    .q_o          (q_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Memory content: narrow word k of wide address a is {101, a, k}.
  function automatic logic [WIDE_WIDTH-1:0] memWord(input logic [12:0] a);
    logic [WIDE_WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < MULTIPLY; k++) w[k*DATA_WIDTH +: DATA_WIDTH] = {3'b101, a, 4'(k)};
    return w;
  endfunction

  // Hand-derived narrow word n (0..127) of page p.
  function automatic logic [DATA_WIDTH-1:0] expWord(input logic [9:0] p, input int n);
    logic [6:0] n7;
    n7 = 7'(n);
    return {3'b101, p, n7};
  endfunction

  task automatic pushPage(input logic [9:0] p);
    for (int n = 0; n < PAGE_SIZE; n++) exp_q.push_back({(n == PAGE_SIZE - 1), expWord(p, n)});
    for (int w = 0; w < WIDE_PER_PAGE; w++) addr_q.push_back({p, 3'(w)});
  endtask

  // One-cycle pulse of start and/or flush.
  task automatic applyStimulus(input logic pg, input logic fl, input logic [9:0] p);
    @(posedge clk_i); #1;
    pgreq_i  = pg;
    flush_i  = fl;
    pgaddr_i = p;
    @(posedge clk_i); #1;
    pgreq_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic waitDrain(input int limit, input logic bp, input string name, output int used);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      dreq_i = bp ? (k % 4 == 0) : 1'b1;
      @(posedge clk_i); #1;
      k++;
    end
    dreq_i = 1'b0;
    used = k;
    checkOutput({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    checkOutput({name, "_addr_done"}, 32'(addr_q.size()), 32'd0);
  endtask

  task automatic waitPops(input int remain, input int limit);
    int k;
    k = 0;
    while (exp_q.size() > remain && k < limit) begin
      dreq_i = 1'b1;
      @(posedge clk_i); #1;
      k++;
    end
  endtask

  // Cycle counter and one-hot sync every 16 cycles.
  always begin
    @(posedge clk_i); #1;
    cyc++;
    sync_i = (cyc % 16 == 0);
  end

  // Memory model: data for the address read in one cycle appears in the next.
  always begin
    logic        rd_s;
    logic [12:0] a_s;
    @(negedge clk_i);
    rd_s = rd_o;
    a_s  = addr_o;
    @(posedge clk_i); #1;
    d_i = rd_s ? memWord(a_s) : {10{$urandom}};
  end

  // Linked-list model: successor of page p is p+2, answered after ll_delay cycles.
  always begin
    logic       lr;
    logic [9:0] la;
    @(negedge clk_i);
    lr = ll_rd_req_o;
    la = ll_addr_o;
    @(posedge clk_i); #1;
    ll_rd_done_i = 1'b0;
    if (!lr) begin
      ll_cnt = 0;
    end else if (ll_cnt >= ll_delay) begin
      ll_rd_done_i = 1'b1;
      ll_data_i    = la + 10'd2;
      ll_cnt       = 0;
    end else begin
      ll_cnt++;
    end
  end

  // Monitor: pops and read addresses are compared against the scoreboard queues.
  always @(negedge clk_i) begin
    logic [DATA_WIDTH:0] e;
    logic [12:0]         ea;
    if (drdy_o && dreq_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL extra_pop: got q_o 0x%0h, expected no word (t=%0t)", q_o, $time);
      end else begin
        e = exp_q.pop_front();
        checkOutput("q_o", 32'(q_o), 32'(e[DATA_WIDTH-1:0]));
        checkOutput("pgend_o", 32'(pgend_o), 32'(e[DATA_WIDTH]));
      end
    end else if (pgend_o) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL pgend_no_pop: got 1, expected 0 (t=%0t)", $time);
    end
    if (rd_o && addr_q.size() != 0) begin
      ea = addr_q.pop_front();
      checkOutput("addr_o", 32'(addr_o), 32'(ea));
    end
  end

  // Hard stop in case something hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int used;
    int rd_cnt;
    int k;

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_drdy", 32'(drdy_o), 32'd0);
    checkOutput("rst_rd", 32'(rd_o), 32'd0);
    checkOutput("rst_llreq", 32'(ll_rd_req_o), 32'd0);
    checkOutput("rst_q", 32'(q_o), 32'd0);

    $display("[TB] test 1: single page then linked page");
    applyStimulus(1'b1, 1'b0, 10'd3);
    pushPage(10'd3);
    pushPage(10'd5);
    waitDrain(1000, 1'b0, "t1", used);
    checkOutput("t1_cycles_le_280", 32'(used <= 280), 32'd1);
    applyStimulus(1'b0, 1'b1, 10'd0);
    exp_q.delete();
    addr_q.delete();

    $display("[TB] test 2: backpressure");
    applyStimulus(1'b1, 1'b0, 10'd3);
    pushPage(10'd3);
    waitDrain(1000, 1'b1, "t2", used);
    applyStimulus(1'b0, 1'b1, 10'd0);
    exp_q.delete();
    addr_q.delete();

    $display("[TB] test 3: linked-list stall");
    ll_delay = 200;
    applyStimulus(1'b1, 1'b0, 10'd3);
    pushPage(10'd3);
    pushPage(10'd5);
    waitPops(128, 400);
    checkOutput("t3_first_page", 32'(exp_q.size()), 32'd128);
    @(negedge clk_i);
    checkOutput("t3_stall_drdy", 32'(drdy_o), 32'd0);
    checkOutput("t3_stall_addr", 32'(addr_q.size()), 32'd8);
    waitDrain(600, 1'b0, "t3", used);
    ll_delay = 4;
    applyStimulus(1'b0, 1'b1, 10'd0);
    exp_q.delete();
    addr_q.delete();

    $display("[TB] test 4: flush mid-page with read in flight");
    applyStimulus(1'b1, 1'b0, 10'd3);
    pushPage(10'd3);
    waitPops(88, 200);
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!rd_o && k < 40);
    checkOutput("t4_rd_seen", 32'(rd_o), 32'd1);
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    checkOutput("t4_flush_drdy", 32'(drdy_o), 32'd0);
    checkOutput("t4_flush_llreq", 32'(ll_rd_req_o), 32'd0);
    dreq_i = 1'b0;
    exp_q.delete();
    addr_q.delete();
    applyStimulus(1'b1, 1'b0, 10'd9);
    pushPage(10'd9);
    waitDrain(400, 1'b0, "t4", used);

    $display("[TB] test 5: start and flush together");
    applyStimulus(1'b1, 1'b1, 10'd12);
    exp_q.delete();
    addr_q.delete();
    pushPage(10'd12);
    waitDrain(400, 1'b0, "t5", used);

    $display("[TB] test 6: reset mid-transfer");
    applyStimulus(1'b1, 1'b0, 10'd3);
    exp_q.delete();
    addr_q.delete();
    pushPage(10'd3);
    waitPops(108, 200);
    dreq_i = 1'b0;
    rst_i  = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("t6_drdy", 32'(drdy_o), 32'd0);
    checkOutput("t6_rd", 32'(rd_o), 32'd0);
    checkOutput("t6_addr", 32'(addr_o), 32'd0);
    checkOutput("t6_q", 32'(q_o), 32'd0);
    checkOutput("t6_pgend", 32'(pgend_o), 32'd0);
    checkOutput("t6_llreq", 32'(ll_rd_req_o), 32'd0);
    checkOutput("t6_lladdr", 32'(ll_addr_o), 32'd0);
    exp_q.delete();
    addr_q.delete();
    rd_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (rd_o) rd_cnt++;
    end
    checkOutput("t6_no_rd", 32'(rd_cnt), 32'd0);
    applyStimulus(1'b1, 1'b0, 10'd6);
    pushPage(10'd6);
    waitDrain(400, 1'b0, "t6", used);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/swc_packet_mem_read_pump.md
Name: swc_packet_mem_read_pump

Overview:
- Read-side counterpart of the packet-memory write pump. Reads 320-bit wide words (16 × 20-bit) from the shared packet memory in its assigned time slot (sync_i). Serialises them into 20-bit words for the output block.
- Follows the page linked list: it fetches the next-page address while the current page drains, then switches pages without gaps.

Parameters:
- PAGE_ADDR_BITS, 10, page address width.
- PAGE_SIZE, 128, narrow words per page. This gives PAGE_SIZE/MULTIPLY = 8 wide words per page.
- DATA_WIDTH, 20, narrow word width.
- MULTIPLY, 16, narrow words per wide memory word.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- pgaddr_i  in  PAGE_ADDR_BITS  start page of packet.
- pgreq_i  in  1  load pgaddr_i and start reading.
- flush_i  in  1  abort the packet and discard buffered data.
- pgend_o  out  1  one-cycle pulse when the last narrow word of a page is popped.
- sync_i  in  1  memory slot grant for this pump.
- rd_o  out  1  memory read strobe.
- addr_o  out  PAGE_ADDR_BITS+3  {page, wide_idx}.
- d_i  in  DATA_WIDTH*MULTIPLY  memory read data, valid on the cycle after rd_o.
- ll_addr_o  out  PAGE_ADDR_BITS  linked-list read address.
- ll_rd_req_o  out  1  linked-list read request.
- ll_data_i  in  PAGE_ADDR_BITS  next-page address.
- ll_rd_done_i  in  1  linked-list read done; ll_data_i is valid in this cycle.
- drdy_o  out  1  q_o valid.
- dreq_i  in  1  consumer pop.
- q_o  out  DATA_WIDTH  narrow output word.

Behaviour:
- Reset (rst_i at a clock edge):
  - All outputs are 0. Buffers are invalid. The pump is inactive.
  - Any in-flight memory read or linked-list request is dropped.
- Storage:
  - Active register A (wide), narrow index nidx 0..15.
  - Holding register H (wide).
  - Valid flags vA, vH.
  - In-flight flag inf.
- Start (pgreq_i):
  - cur_page <= pgaddr_i; wide_idx <= 0; vA, vH and inf are cleared; active <= 1.
  - The linked-list FSM is restarted for the new page.
  - A read in flight at this time is discarded: its returning data is not written.
- Memory read issue:
  - rd_o = active & sync_i & !vH & !inf & page_ok, where page_ok means wide_idx ≤ 7 for the current page.
  - addr_o = {cur_page, wide_idx}, driven combinationally with rd_o.
  - On issue: inf <= 1 and wide_idx increments.
- Memory read return (cycle after rd_o): d_i goes into A if !vA or if A is being fully consumed in that cycle; otherwise into H. inf <= 0.
- Page switch:
  - Condition: after wide word 7 has been issued and the linked-list FSM is in LL_HAVE.
  - Action: cur_page <= next_page, wide_idx <= 0, linked-list FSM restarts on the new page.
  - If next_page is not yet known, reads stall; this is not an error.
- Output:
  - drdy_o = vA. q_o = A[nidx*20 +: 20], so the first word is in the LSBs.
  - Pop when drdy_o & dreq_i: nidx increments.
  - Pop at nidx = 15: nidx <= 0, A <= H, vA <= vH, vH <= 0. If data returns in the same cycle it fills the freed slot, so no word is lost.
- pgend_o: pulses in the cycle of the pop of the last narrow word of a page (wide word 7, nidx 15).
- Linked-list FSM:
  - LL_IDLE → LL_REQ on start or page switch. In LL_REQ, ll_addr_o = cur_page and ll_rd_req_o = 1, held until ll_rd_done_i.
  - LL_REQ → LL_HAVE on ll_rd_done_i; next_page <= ll_data_i.
  - Any state → LL_IDLE on flush_i or reset.
- flush_i:
  - active <= 0; vA, vH, inf and nidx are cleared; the FSM goes to LL_IDLE.
  - drdy_o drops the next cycle. In-flight data is ignored.
- Precedence: rst_i > pgreq_i > flush_i > normal operation.
- Timing:
  - Latency from pgreq_i to the first drdy_o is at most 16 + 2 cycles, given a sync period of 16.
  - Sustained throughput is 1 narrow word per cycle when sync_i arrives every 16 cycles.

Decomposition:
- Shared package swc_pump_pkg:
  - Constants: PAGE_ADDR_BITS, PAGE_SIZE, DATA_WIDTH, MULTIPLY, and derived WIDE_PER_PAGE = 8.
  - Linked-list FSM state encoding, also used by the write pump.
- Sub-module swc_pump_unpacker: the A/H double buffer, nidx counter, q_o mux and pop logic.
- The top level keeps the page, read-issue and linked-list logic.

Test Plan:
1. Single page, one-hot sync with period 16, dreq_i held at 1, ll_data_i = 5 returned 4 cycles after the request.
   - pgreq_i with pgaddr_i = 3: addr_o goes 0x018..0x01F, q_o carries 128 words matching the memory model, pgend_o pulses once on the 128th pop.
   - Then the pump reads page 5 (addr_o 0x028).
2. Backpressure: dreq_i toggles 1 cycle on, 3 off.
   - No word is lost or duplicated. rd_o is never asserted while vH = 1.
3. Linked-list stall: ll_rd_done_i is delayed 200 cycles.
   - Reads stop after wide word 7. drdy_o drops after 128 pops.
   - Output resumes with page 5 data once done arrives.
4. flush_i mid-page (after 40 pops), with a read in flight.
   - drdy_o = 0 the next cycle. ll_rd_req_o = 0.
   - A new pgreq_i with pgaddr_i = 9 yields page 9 data only (addr_o 0x048).
5. pgreq_i and flush_i in the same cycle: start wins and reading of the new page proceeds.
6. rst_i mid-transfer: all outputs are 0 the next cycle. No rd_o is issued until a new pgreq_i.
